// File: rtl/mtime_sched.sv
// mtime_sched
// Virtual-timer scheduler between software-visible timer slots and the
// machine timer's DBus port. Keeps NUM_SLOTS 64-bit deadlines and programs
// mtimecmp with the earliest armed deadline. On a machine-timer interrupt
// every armed slot whose deadline has passed is flagged expired and
// mtimecmp is reprogrammed. This block is the only writer of mtimecmp.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   cfg_en/op/slot/deadline
//                   slot config command (01 arm, 10 disarm), single cycle
//   clr_en/clr_mask clear sticky expired flags
//   time_now        current mtime value
//   timer_irq       timer interrupt (mtime >= mtimecmp)
//   tmr_*           timer port write interface (addr 2 = cmp lo, 3 = cmp hi)
//   armed, expired  per-slot status flags
//   irq             any slot expired
//   busy            scan or write sequence in progress
module mtime_sched #(
   parameter  int NUM_SLOTS = 4,
   localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_en,
   input  logic [1:0]           cfg_op,
   input  logic [SLOT_W-1:0]    cfg_slot,
   input  logic [63:0]          cfg_deadline,
   input  logic                 clr_en,
   input  logic [NUM_SLOTS-1:0] clr_mask,
   input  logic [63:0]          time_now,
   input  logic                 timer_irq,
   output logic                 tmr_rd_en,
   output logic                 tmr_wr_en,
   output logic [1:0]           tmr_addr,
   output logic [31:0]          tmr_wr_data,
   output logic [3:0]           tmr_wr_strobe,
   output logic [NUM_SLOTS-1:0] armed,
   output logic [NUM_SLOTS-1:0] expired,
   output logic                 irq,
   output logic                 busy
);

   localparam logic [1:0]        OP_ARM    = 2'b01;
   localparam logic [1:0]        OP_DISARM = 2'b10;
   localparam logic [SLOT_W-1:0] LAST_IDX  = SLOT_W'(NUM_SLOTS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      WR_HI_MAX,
      WR_LO,
      WR_HI
   } state_t;

   state_t state;
   state_t state_nx;

   logic [63:0]          deadline [NUM_SLOTS];
   logic [63:0]          snap;
   logic [63:0]          best;
   logic [SLOT_W-1:0]    idx;
   logic                 rescan_pend;

   logic                 cfg_arm;
   logic                 cfg_disarm;
   logic                 cfg_hit_idx;
   logic                 start_scan;
   logic                 scan_expire;
   logic                 scan_better;
   logic [NUM_SLOTS-1:0] armed_nx;
   logic [NUM_SLOTS-1:0] expired_nx;

   assign cfg_arm       = cfg_en && (cfg_op == OP_ARM);
   assign cfg_disarm    = cfg_en && (cfg_op == OP_DISARM);
   // A config command aimed at the slot being scanned this cycle takes
   // precedence, so the scan leaves that slot alone entirely.
   assign cfg_hit_idx   = (cfg_arm || cfg_disarm) && (cfg_slot == idx);
   assign start_scan    = (state == IDLE) && (rescan_pend || timer_irq);

   assign tmr_rd_en     = 1'b0;
   assign tmr_wr_strobe = 4'hF;
   assign irq           = |expired;
   assign busy          = (state != IDLE);

   // Evaluate the slot under the scan pointer: either it has already
   // passed the snapshot time and expires, or it may be the new minimum.
   always_comb begin
      scan_expire = 1'b0;
      scan_better = 1'b0;
      if ((state == SCAN) && armed[idx] && !cfg_hit_idx) begin
         if (deadline[idx] <= snap) begin
            scan_expire = 1'b1;
         end else if (deadline[idx] < best) begin
            scan_better = 1'b1;
         end
      end
   end

   // Next value of the per-slot flags. Order matters: the clear goes
   // first so a scan setting the same bit wins, and config commands go
   // last so they override the scan for their slot.
   always_comb begin
      armed_nx   = armed;
      expired_nx = expired;
      if (clr_en) begin
         expired_nx = expired_nx & ~clr_mask;
      end
      if (scan_expire) begin
         expired_nx[idx] = 1'b1;
         armed_nx[idx]   = 1'b0;
      end
      if (cfg_arm) begin
         armed_nx[cfg_slot]   = 1'b1;
         expired_nx[cfg_slot] = 1'b0;
      end else if (cfg_disarm) begin
         armed_nx[cfg_slot] = 1'b0;
      end
   end

   // Sequencer: scan every slot once, then write mtimecmp hi as all-ones
   // before touching lo so no spurious interrupt can fire mid-update.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (rescan_pend || timer_irq) state_nx = SCAN;
         SCAN:      if (idx == LAST_IDX) state_nx = WR_HI_MAX;
         WR_HI_MAX: state_nx = WR_LO;
         WR_LO:     state_nx = WR_HI;
         WR_HI:     state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Slot storage, scan pointer, snapshot and running minimum. A config
   // command arriving on the same edge a scan starts keeps rescan_pend set,
   // so nothing is ever lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            deadline[i] <= '0;
         end
         armed       <= '0;
         expired     <= '0;
         rescan_pend <= 1'b0;
         snap        <= '0;
         best        <= '1;
         idx         <= '0;
      end else begin
         armed   <= armed_nx;
         expired <= expired_nx;
         if (cfg_arm) begin
            deadline[cfg_slot] <= cfg_deadline;
         end
         if (start_scan) begin
            snap <= time_now;
            idx  <= '0;
            best <= '1;
         end else if (state == SCAN) begin
            idx <= idx + SLOT_W'(1);
            if (scan_better) begin
               best <= deadline[idx];
            end
         end
         if (cfg_arm || cfg_disarm) begin
            rescan_pend <= 1'b1;
         end else if (start_scan) begin
            rescan_pend <= 1'b0;
         end
      end
   end

   // Registered timer port: driven from the state being entered so each
   // write lines up with exactly one cycle of its write state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmr_wr_en   <= 1'b0;
         tmr_addr    <= 2'd0;
         tmr_wr_data <= '0;
      end else begin
         tmr_wr_en   <= 1'b0;
         tmr_addr    <= 2'd0;
         tmr_wr_data <= '0;
         case (state_nx)
            WR_HI_MAX: begin
               tmr_wr_en   <= 1'b1;
               tmr_addr    <= 2'd3;
               tmr_wr_data <= 32'hFFFF_FFFF;
            end
            WR_LO: begin
               tmr_wr_en   <= 1'b1;
               tmr_addr    <= 2'd2;
               tmr_wr_data <= best[31:0];
            end
            WR_HI: begin
               tmr_wr_en   <= 1'b1;
               tmr_addr    <= 2'd3;
               tmr_wr_data <= best[63:32];
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/mtime_sched.md
Name: mtime_sched

Overview:
- Virtual-timer scheduler sitting between software-visible timer slots and the machine timer's DBus port.
- Holds NUM_SLOTS 64-bit deadlines and keeps the timer compare register (mtimecmp) programmed with the earliest armed deadline.
- On machine-timer interrupt, marks every slot whose deadline has passed as expired, then reprograms mtimecmp.
- Is the sole writer of mtimecmp. The core reads time/timeh through the time CSR path only.

Parameters:
- NUM_SLOTS, 4, number of virtual timer slots (2..16).
- SLOT_W, $clog2(NUM_SLOTS), slot index width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- cfg_en  input  1  slot config command valid; always accepted, single cycle.
- cfg_op  input  2  2'b01 arm, 2'b10 disarm; other codes are ignored.
- cfg_slot  input  SLOT_W  target slot.
- cfg_deadline  input  64  absolute deadline in mtime ticks; used by arm only.
- clr_en  input  1  clear expired flags.
- clr_mask  input  NUM_SLOTS  expired bits to clear.
- time_now  input  64  current mtime value (timer's time_rd_data).
- timer_irq  input  1  timer interrupt (mtime >= mtimecmp).
- tmr_rd_en  output  1  timer port read enable; tied 0.
- tmr_wr_en  output  1  timer port write enable.
- tmr_addr  output  2  timer port address; 2=mtimecmp lo, 3=mtimecmp hi.
- tmr_wr_data  output  32  timer write data.
- tmr_wr_strobe  output  4  timer byte enables; always 4'hF.
- armed  output  NUM_SLOTS  per-slot armed flags.
- expired  output  NUM_SLOTS  per-slot sticky expired flags.
- irq  output  1  |expired.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: all slot deadlines 0; armed=0; expired=0; irq=0; busy=0; tmr_wr_en=0; tmr_addr=0; tmr_wr_data=0; rescan_pend=0; state IDLE. Reset mid-sequence aborts at the next edge with no further writes. mtimecmp keeps whatever partial value it had; it is the timer's own reset that clears it.
- Arm: at the edge, deadline[slot] <= cfg_deadline, armed[slot] <= 1, expired[slot] <= 0, rescan_pend <= 1.
- Disarm: armed[slot] <= 0, rescan_pend <= 1. The expired flag is untouched.
- Config commands are honoured in every state, including while busy.
- States: IDLE, SCAN, WR_HI_MAX, WR_LO, WR_HI.
- IDLE -> SCAN when rescan_pend || timer_irq. On entry: snap <= time_now, idx <= 0, best <= 64'hFFFF_FFFF_FFFF_FFFF, rescan_pend <= 0.
- SCAN: one slot per cycle, idx 0..NUM_SLOTS-1, so exactly NUM_SLOTS cycles.
  - If armed[idx] && deadline[idx] <= snap: expired[idx] <= 1, armed[idx] <= 0.
  - Else if armed[idx] && deadline[idx] < best: best <= deadline[idx].
  - A config command to the same slot in the same cycle overrides the scan update for that slot.
- WR_HI_MAX: tmr_wr_en=1, addr=3, data=32'hFFFF_FFFF. This prevents a spurious interrupt while the low word is changing.
- WR_LO: tmr_wr_en=1, addr=2, data=best[31:0].
- WR_HI: tmr_wr_en=1, addr=3, data=best[63:32]. Next state is IDLE.
- Timer write outputs are registered and asserted exactly one cycle per write state; tmr_wr_en=0 in IDLE and SCAN.
- No armed slot remaining: best stays all-ones, so mtimecmp becomes 2^64-1 (effectively never fires).
- timer_irq is ignored outside IDLE. A deadline passing during the write sequence raises timer_irq after WR_HI, which triggers a new scan from IDLE.
- rescan_pend set while busy: a further scan starts the cycle after returning to IDLE.
- Latency: config command at edge k -> SCAN during cycles k+1..k+N -> writes at k+N+1..k+N+3 -> IDLE at k+N+4.
- Clear: expired &= ~clr_mask. If a scan sets a bit in the same cycle it is cleared, the set wins.
- irq is combinational from expired.
- Deadline comparisons are unsigned 64-bit; wrap-around is not handled because a 64-bit µs counter does not wrap in practice.

Test Plan:
- Arm slot0 deadline 100 with time_now=10 -> after 4 SCAN cycles, writes (3,FFFFFFFF), (2,00000064), (3,00000000) on consecutive cycles; busy deasserts; armed=0001.
- With slot0 armed at 100, drive time_now=100 and timer_irq=1 -> expired[0]=1, irq=1, armed=0; mtimecmp programmed to FFFFFFFF_FFFFFFFF.
- Arm slot1=500, slot2=300, slot3=0x1_0000_0010 -> final writes program lo=0000012C, hi=0; expiry of slot2 at 300 reprograms to 500, then to 0x1_0000_0010 (lo=00000010, hi=00000001).
- Arm slot0 with deadline 5 while time_now=50 -> expired[0] set during SCAN and never programmed; clr_en with mask 0001 in the same cycle as the set -> bit stays 1; clr next cycle -> bit 0, irq=0.
- Arm slot1 during SCAN cycle 2 -> current sequence completes, then a second SCAN starts right after IDLE; final mtimecmp equals the new minimum.
- Assert rst_n=0 during WR_LO -> next cycle tmr_wr_en=0, state IDLE, armed=0, expired=0, busy=0.
